nanov_mmio: RTL and testbench

//  Memory-mapped IO slave sitting directly downstream of the nanoV CPU's external data port.

---
 rtl/nanov_pkg.sv | 28 ++
 rtl/nanov_uart_rx.sv | 104 ++++++++++
 rtl/nanov_mmio.sv | 149 ++++++++++++++
 tb/tb_nanov_mmio.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nanov_pkg.sv
// Shared definitions for the nanoV MMIO block: register offsets, STAT bit
// positions, UART FSM states and the CPU store-data bit reversal.
package nanov_pkg;

  localparam logic [2:0] MMIO_GPIO_OUT  = 3'd0;
  localparam logic [2:0] MMIO_GPIO_IN   = 3'd1;
  localparam logic [2:0] MMIO_UART_DATA = 3'd2;
  localparam logic [2:0] MMIO_UART_STAT = 3'd3;

  localparam int STAT_TX_BUSY    = 0;
  localparam int STAT_RX_VALID   = 1;
  localparam int STAT_RX_OVERRUN = 2;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  // The CPU shifts store data out MSB-first, so bit i arrives at position 31-i
  function automatic logic [31:0] bitrev32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

endpackage

// File: rtl/nanov_uart_rx.sv
// 8N1 UART receiver: input synchroniser, start/mid-bit sampling FSM and a
// one-byte buffer with valid and overrun flags.
module nanov_uart_rx
  import nanov_pkg::*;
#(
  parameter int CLKS_PER_BIT = 52
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       pop,
  input  logic       clr_overrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // sync[1] is the synchronised line, sync[2] its previous value for edge detect
  logic [2:0]  sync;
  logic        rx_s, rx_prev;
  uart_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        done;

  assign rx_s    = sync[1];
  assign rx_prev = sync[2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync  <= 3'b111;
      state <= UART_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      sync  <= {sync[1:0], rxd};
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    done    = 1'b0;
    case (state)
      UART_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (rx_prev && !rx_s) state_n = UART_START;
      end
      UART_START: begin
        // A start bit that is gone by mid-bit was a glitch
        if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? UART_IDLE : UART_DATA;
        end else cnt_n = cnt + 1'b1;
      end
      UART_DATA: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          if (idx == 3'd7) state_n = UART_STOP;
          else idx_n = idx + 3'd1;
        end else cnt_n = cnt + 1'b1;
      end
      UART_STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = UART_IDLE;
          done    = rx_s;
        end else cnt_n = cnt + 1'b1;
      end
      default: state_n = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (done) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (pop) rx_valid <= 1'b0;
      // A pop in the completion cycle makes room for the new byte
      if (done && rx_valid && !pop) rx_overrun <= 1'b1;
      else if (clr_overrun)         rx_overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/nanov_mmio.sv
// nanoV memory-mapped IO slave: address capture, GPIO registers, UART TX and
// a registered read-data snapshot taken when the address arrives.
module nanov_mmio
  import nanov_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 52,
  parameter int         GPIO_WIDTH   = 8,
  parameter logic [3:0] IO_BASE      = 4'h1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [31:0]           data_out,
  input  logic                  store_addr_out,
  input  logic                  store_data_out,
  input  logic                  data_in_read,
  output logic [31:0]           ext_data_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  uart_txd,
  input  logic                  uart_rxd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [31:0]           addr_q, wdata, rd_mux;
  logic                  addr_pend, rd_sel, sel, wr;
  logic [2:0]            off;
  logic [GPIO_WIDTH-1:0] gpio_s1, gpio_s2;
  logic [7:0]            rx_data;
  logic                  rx_valid, rx_overrun, pop, clr_overrun;
  uart_state_e           tx_state, tx_state_n;
  logic [CW-1:0]         tx_cnt, tx_cnt_n;
  logic [2:0]            tx_idx, tx_idx_n;
  logic [7:0]            tx_shift, tx_shift_n;
  logic                  tx_busy, tx_start;
  logic                  unused;

  assign sel         = (addr_q[31:28] == IO_BASE);
  assign off         = addr_q[4:2];
  assign wdata       = bitrev32(data_out);
  assign wr          = store_data_out && sel;
  assign tx_busy     = (tx_state != UART_IDLE);
  assign tx_start    = wr && (off == MMIO_UART_DATA) && !tx_busy;
  assign pop         = data_in_read && rd_sel && (off == MMIO_UART_DATA);
  assign clr_overrun = data_in_read && rd_sel && (off == MMIO_UART_STAT);
  assign unused      = ^{addr_q[27:5], addr_q[1:0], wdata[31:8]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      addr_pend   <= 1'b0;
      rd_sel      <= 1'b0;
      ext_data_in <= '0;
      gpio_s1     <= '0;
      gpio_s2     <= '0;
      gpio_out    <= '0;
    end else begin
      gpio_s1   <= gpio_in;
      gpio_s2   <= gpio_s1;
      addr_pend <= store_addr_out;
      if (store_addr_out) addr_q <= data_out;
      // rd_sel arms data_in_read side effects only for a selected load
      if (store_addr_out)    rd_sel <= 1'b0;
      else if (addr_pend)    rd_sel <= sel;
      else if (data_in_read) rd_sel <= 1'b0;
      if (addr_pend) ext_data_in <= sel ? rd_mux : '0;
      if (wr && off == MMIO_GPIO_OUT) gpio_out <= wdata[GPIO_WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      MMIO_GPIO_OUT:  rd_mux = 32'(gpio_out);
      MMIO_GPIO_IN:   rd_mux = 32'(gpio_s2);
      MMIO_UART_DATA: rd_mux = 32'(rx_data);
      MMIO_UART_STAT: begin
        rd_mux[STAT_TX_BUSY]    = tx_busy;
        rd_mux[STAT_RX_VALID]   = rx_valid;
        rd_mux[STAT_RX_OVERRUN] = rx_overrun;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= UART_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    if (tx_state == UART_IDLE) begin
      tx_cnt_n = '0;
      tx_idx_n = '0;
      if (tx_start) begin
        tx_shift_n = wdata[7:0];
        tx_state_n = UART_START;
      end
    end else if (tx_cnt != LAST) begin
      tx_cnt_n = tx_cnt + 1'b1;
    end else begin
      tx_cnt_n = '0;
      case (tx_state)
        UART_START: tx_state_n = UART_DATA;
        UART_DATA: begin
          if (tx_idx == 3'd7) tx_state_n = UART_STOP;
          else tx_idx_n = tx_idx + 3'd1;
        end
        default: tx_state_n = UART_IDLE;
      endcase
    end
  end

  // Decoded straight from state so reset forces the line idle without a clock
  always_comb begin
    uart_txd = 1'b1;
    case (tx_state)
      UART_START: uart_txd = 1'b0;
      UART_DATA:  uart_txd = tx_shift[tx_idx];
      default:    uart_txd = 1'b1;
    endcase
  end

  nanov_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rstn        (rstn),
    .rxd         (uart_rxd),
    .pop         (pop),
    .clr_overrun (clr_overrun),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_overrun  (rx_overrun)
  );

endmodule

// File: tb/tb_nanov_mmio.sv
// Directed bench for nanov_mmio: a register vector table plus hand-written
// UART TX/RX and asynchronous reset sequences.
module tb_nanov_mmio;
  import nanov_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] data_out;
  logic        store_addr_out, store_data_out, data_in_read;
  logic [31:0] ext_data_in;
  logic [7:0]  gpio_out, gpio_in;
  logic        uart_txd, uart_rxd;

  int total = 0;
  int passed = 0;

  nanov_mmio #(.CLKS_PER_BIT(CPB), .GPIO_WIDTH(8), .IO_BASE(4'h1)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .data_out       (data_out),
    .store_addr_out (store_addr_out),
    .store_data_out (store_data_out),
    .data_in_read   (data_in_read),
    .ext_data_in    (ext_data_in),
    .gpio_out       (gpio_out),
    .gpio_in        (gpio_in),
    .uart_txd       (uart_txd),
    .uart_rxd       (uart_rxd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // All tasks are entered and left on a negedge
  task automatic do_load(input logic [31:0] a);
    data_out = a; store_addr_out = 1'b1;
    @(negedge clk);
    store_addr_out = 1'b0; data_out = '0;
    @(negedge clk);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [7:0] d);
    data_out = a; store_addr_out = 1'b1;
    @(negedge clk);
    store_addr_out = 1'b0; data_out = bitrev32({24'h0, d}); store_data_out = 1'b1;
    @(negedge clk);
    store_data_out = 1'b0; data_out = '0;
  endtask

  task automatic pulse_read();
    data_in_read = 1'b1;
    @(negedge clk);
    data_in_read = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  // Expected TX line n clocks after the write edge
  function automatic logic exp_tx(input logic [7:0] b, input int n);
    int slot;
    slot = n / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  initial begin
    rstn = 1'b0; data_out = '0; store_addr_out = 1'b0; store_data_out = 1'b0;
    data_in_read = 1'b0; gpio_in = 8'h3C; uart_rxd = 1'b1;
    vecs[0]  = '{1'b0, 32'h1000_0000, 8'hA5, 32'hA5, "gpio_wr_a5"};
    vecs[1]  = '{1'b1, 32'h1000_0000, 8'h00, 32'hA5, "gpio_out_rd"};
    vecs[2]  = '{1'b1, 32'h1000_0004, 8'h00, 32'h3C, "gpio_in_rd"};
    vecs[3]  = '{1'b1, 32'h1000_0014, 8'h00, 32'h00, "unmapped_rd"};
    vecs[4]  = '{1'b0, 32'h2000_0000, 8'hFF, 32'hA5, "unsel_wr"};
    vecs[5]  = '{1'b1, 32'h0000_1000, 8'h00, 32'h00, "unsel_rd"};
    vecs[6]  = '{1'b0, 32'h1000_0004, 8'h11, 32'hA5, "ro_wr"};
    vecs[7]  = '{1'b0, 32'h1000_0003, 8'h5A, 32'h5A, "gpio_wr_lowbits"};
    vecs[8]  = '{1'b1, 32'h1000_000C, 8'h00, 32'h00, "stat_idle"};
    vecs[9]  = '{1'b1, 32'h1000_0002, 8'h00, 32'h5A, "rd_lowbits"};
    vecs[10] = '{1'b0, 32'h1000_001C, 8'h99, 32'h5A, "unmapped_wr"};

    repeat (3) @(negedge clk);
    check("rst_ext", ext_data_in, 32'h0);
    check("rst_gpio", {24'h0, gpio_out}, 32'h0);
    check("rst_txd", {31'h0, uart_txd}, 32'h1);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_load) begin
        do_load(vecs[i].addr);
        check(vecs[i].name, ext_data_in, vecs[i].exp);
      end else begin
        do_store(vecs[i].addr, vecs[i].data);
        check(vecs[i].name, {24'h0, gpio_out}, vecs[i].exp);
      end
    end

    // Read value held across data_in_read
    do_load(32'h1000_0004);
    check("hold_pre", ext_data_in, 32'h3C);
    pulse_read();
    check("hold_read", ext_data_in, 32'h3C);
    repeat (3) @(negedge clk);
    check("hold_late", ext_data_in, 32'h3C);

    // TX frame 0x55
    do_store(32'h1000_0008, 8'h55);
    for (int n = 0; n < 44; n++) begin
      check($sformatf("tx55_n%0d", n), {31'h0, uart_txd}, {31'h0, exp_tx(8'h55, n)});
      @(negedge clk);
    end
    do_load(32'h1000_000C);
    check("tx_done_stat", ext_data_in, 32'h0);

    // TX frame 0xF0 with a dropped write mid-frame
    do_store(32'h1000_0008, 8'hF0);
    do_load(32'h1000_000C);
    check("tx_busy_stat", ext_data_in, 32'h1);
    do_store(32'h1000_0008, 8'h0F);
    for (int n = 4; n < 48; n++) begin
      check($sformatf("txf0_n%0d", n), {31'h0, uart_txd}, {31'h0, exp_tx(8'hF0, n)});
      @(negedge clk);
    end
    do_load(32'h1000_000C);
    check("tx2_done_stat", ext_data_in, 32'h0);

    // RX single frame and pop
    send_rx(8'h5A);
    do_load(32'h1000_0008);
    check("rx_data", ext_data_in, 32'h5A);
    pulse_read();
    do_load(32'h1000_000C);
    check("rx_popped_stat", ext_data_in, 32'h0);

    // data_in_read after an unselected load must not pop
    send_rx(8'h77);
    do_load(32'h0000_1000);
    pulse_read();
    do_load(32'h1000_000C);
    check("rx_nopop_stat", ext_data_in, 32'h2);
    do_load(32'h1000_0008);
    check("rx_77", ext_data_in, 32'h77);
    pulse_read();

    // Overrun: second byte overwrites, flag cleared by reading STAT
    send_rx(8'h12);
    send_rx(8'h34);
    do_load(32'h1000_000C);
    check("ovr_stat", ext_data_in, 32'h6);
    do_load(32'h1000_0008);
    check("ovr_data", ext_data_in, 32'h34);
    pulse_read();
    do_load(32'h1000_000C);
    check("ovr_after_pop", ext_data_in, 32'h4);
    pulse_read();
    do_load(32'h1000_000C);
    check("ovr_cleared", ext_data_in, 32'h0);

    // Asynchronous reset during TX data bit 3 of 0x55 (line low there)
    do_store(32'h1000_0008, 8'h55);
    repeat (18) @(negedge clk);
    check("pre_rst_txd", {31'h0, uart_txd}, 32'h0);
    #1 rstn = 1'b0;
    #1;
    check("async_rst_txd", {31'h0, uart_txd}, 32'h1);
    check("async_rst_gpio", {24'h0, gpio_out}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_load(32'h1000_000C);
    check("post_rst_stat", ext_data_in, 32'h0);
    do_load(32'h1000_0000);
    check("post_rst_gpio", ext_data_in, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
